// File: rtl/tank_pkg.sv
// Shared types and 7-segment patterns for the tank level controller.
//   state_t  : controller FSM states
//   level_t  : level class, encoded exactly as driven on level_code
//   SEG_*    : segment patterns for the level letter display
package tank_pkg;

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_IDLE  = 2'd1,
      S_FILL  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      HIGH = 2'b00,
      MID  = 2'b01,
      LOW  = 2'b10,
      FLT  = 2'b11
   } level_t;

   localparam logic [7:0] SEG_A    = 8'b0111_0111;
   localparam logic [7:0] SEG_N    = 8'b0101_0100;
   localparam logic [7:0] SEG_B    = 8'b0111_1100;
   localparam logic [7:0] SEG_D    = 8'b0101_1110;
   localparam logic [7:0] SEG_DASH = 8'b0100_0000;
   localparam logic [7:0] SEG_OFF  = 8'b0000_0000;

   // An invalid vector outside S_FAULT shows a steady "d".
   function automatic logic [7:0] level_seg(level_t lvl);
      case (lvl)
         HIGH:    return SEG_A;
         MID:     return SEG_N;
         LOW:     return SEG_B;
         default: return SEG_D;
      endcase
   endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a stability debouncer.
//   clk_2    in  clock
//   reset_n  in  asynchronous active-low reset
//   d_in     in  W   raw asynchronous inputs
//   stable   out W   last accepted vector
//   accepted out 1   one-cycle pulse when a vector has been stable DEB_CYCLES samples
module input_debounce #(
   parameter int W          = 4,
   parameter int DEB_CYCLES = 4
) (
   input  logic         clk_2,
   input  logic         reset_n,
   input  logic [W-1:0] d_in,
   output logic [W-1:0] stable,
   output logic         accepted
);

   localparam int            CW      = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);

   logic [W-1:0]  sync1;
   logic [W-1:0]  sync2;
   logic [W-1:0]  prev;
   logic [CW-1:0] cnt;
   logic          same;

   assign same = (sync2 == prev);

   // The counter saturates at DEB_CYCLES, so a held vector is accepted once
   // and only a change in the synced vector re-arms it.
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         sync1    <= '0;
         sync2    <= '0;
         prev     <= '0;
         cnt      <= '0;
         stable   <= '0;
         accepted <= 1'b0;
      end else begin
         sync1    <= d_in;
         sync2    <= sync1;
         prev     <= sync2;
         accepted <= 1'b0;
         if (!same) begin
            cnt <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_MAX - 1'b1) begin
               stable   <= sync2;
               accepted <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tank_level_ctrl.sv
// Tank level controller: debounced float-switch thermometer code in,
// pump command, fault alarm, level class and 7-seg letter out.
//   clk_2       in  clock
//   reset_n     in  asynchronous active-low reset
//   sensor      in  NSENS raw float switches, bit0 = lowest
//   pump_on     out pump command (S_FILL)
//   alarm       out fault indicator (S_FAULT)
//   level_code  out 00 HIGH, 01 MID, 10 LOW, 11 FAULT/INIT
//   seg         out 7-seg pattern
//
// state   | meaning
// S_INIT  | waiting for a first accepted sensor vector
// S_IDLE  | level MID/HIGH, pump off
// S_FILL  | pumping until HIGH, dry-run watchdog running
// S_FAULT | invalid sensors or fill timeout, blinking "d"
module tank_level_ctrl
   import tank_pkg::*;
#(
   parameter int NSENS        = 4,
   parameter int LO_TH        = 1,
   parameter int HI_TH        = NSENS,
   parameter int DEB_CYCLES   = 4,
   parameter int FAULT_CYCLES = 8,
   parameter int FILL_TIMEOUT = 64,
   parameter int BLINK        = 16
) (
   input  logic             clk_2,
   input  logic             reset_n,
   input  logic [NSENS-1:0] sensor,
   output logic             pump_on,
   output logic             alarm,
   output logic [1:0]       level_code,
   output logic [7:0]       seg
);

   localparam int            KW      = $clog2(NSENS + 1);
   localparam int            FW      = $clog2(FAULT_CYCLES + 1);
   localparam int            WW      = $clog2(FILL_TIMEOUT + 1);
   localparam int            BW      = $clog2(BLINK + 1);
   localparam logic [FW-1:0] FC_MAX  = FW'(FAULT_CYCLES);
   localparam logic [WW-1:0] WD_MAX  = WW'(FILL_TIMEOUT);
   localparam logic [BW-1:0] BL_LAST = BW'(BLINK - 1);

   logic [NSENS-1:0] stable;
   logic             accepted;
   logic             seen_acc;
   logic [KW-1:0]    k;
   logic [KW-1:0]    k_last;
   logic [NSENS-1:0] mask;
   logic             valid;
   level_t           cls;
   logic [FW-1:0]    inv_cnt;
   logic [FW-1:0]    val_cnt;
   logic [WW-1:0]    wd_cnt;
   logic [BW-1:0]    blink_cnt;
   state_t           state;
   state_t           state_n;

   input_debounce #(.W(NSENS), .DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk_2    (clk_2),
      .reset_n  (reset_n),
      .d_in     (sensor),
      .stable   (stable),
      .accepted (accepted)
   );

   // Valid means a contiguous run of ones from bit0, i.e. stable equals the
   // mask of its own popcount.
   always_comb begin
      k = '0;
      for (int i = 0; i < NSENS; i++) k = k + KW'(stable[i]);
      mask = '0;
      for (int i = 0; i < NSENS; i++) if (KW'(i) < k) mask[i] = 1'b1;
      valid = (stable == mask);
      if (!valid)                 cls = FLT;
      else if (k >= KW'(HI_TH))   cls = HIGH;
      else if (k <  KW'(LO_TH))   cls = LOW;
      else                        cls = MID;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_INIT: begin
            // seen_acc keeps S_INIT able to leave after a fault recovery,
            // when the held vector was already accepted before the fault.
            if (inv_cnt == FC_MAX)                               state_n = S_FAULT;
            else if ((accepted || seen_acc) && cls == LOW)       state_n = S_FILL;
            else if ((accepted || seen_acc) && (cls == MID || cls == HIGH))
                                                                 state_n = S_IDLE;
         end
         S_IDLE: begin
            if (inv_cnt == FC_MAX)  state_n = S_FAULT;
            else if (cls == LOW)    state_n = S_FILL;
         end
         S_FILL: begin
            if (inv_cnt == FC_MAX)      state_n = S_FAULT;
            else if (wd_cnt == WD_MAX)  state_n = S_FAULT;
            else if (cls == HIGH)       state_n = S_IDLE;
         end
         S_FAULT: begin
            if (val_cnt == FC_MAX)  state_n = S_INIT;
         end
         default: state_n = S_INIT;
      endcase
   end

   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_INIT;
         seen_acc <= 1'b0;
         inv_cnt  <= '0;
         val_cnt  <= '0;
      end else begin
         state    <= state_n;
         seen_acc <= seen_acc | accepted;
         if (!valid) begin
            val_cnt <= '0;
            if (inv_cnt != FC_MAX) inv_cnt <= inv_cnt + 1'b1;
         end else begin
            inv_cnt <= '0;
            if (val_cnt != FC_MAX) val_cnt <= val_cnt + 1'b1;
         end
      end
   end

   // Dry-run watchdog: counts FILL cycles since the level last rose.
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt <= '0;
         k_last <= '0;
      end else if (state_n == S_FILL && state != S_FILL) begin
         wd_cnt <= '0;
         k_last <= k;
      end else if (state == S_FILL) begin
         if (k > k_last) begin
            wd_cnt <= '0;
            k_last <= k;
         end else if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
      end else begin
         wd_cnt <= '0;
      end
   end

   // Outputs follow state_n so they switch on the same edge as the state.
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         pump_on    <= 1'b0;
         alarm      <= 1'b0;
         level_code <= 2'b11;
         seg        <= SEG_DASH;
         blink_cnt  <= '0;
      end else begin
         pump_on <= (state_n == S_FILL);
         alarm   <= (state_n == S_FAULT);
         case (state_n)
            S_INIT: begin
               level_code <= 2'b11;
               seg        <= SEG_DASH;
            end
            S_FAULT: begin
               level_code <= 2'b11;
               if (state != S_FAULT) begin
                  seg       <= SEG_D;
                  blink_cnt <= '0;
               end else if (blink_cnt == BL_LAST) begin
                  blink_cnt <= '0;
                  seg       <= (seg == SEG_OFF) ? SEG_D : SEG_OFF;
               end else begin
                  blink_cnt <= blink_cnt + 1'b1;
               end
            end
            default: begin
               level_code <= cls;
               seg        <= level_seg(cls);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tank_level_ctrl.sv
module tb_tank_level_ctrl;

   localparam int NS = 4, LO = 1, HI = 4, DEB = 4, FC = 8, TO = 64, BL = 16;
   localparam int HMAX = 12000;
   localparam logic [7:0] S_A = 8'b0111_0111, S_N = 8'b0101_0100, S_B = 8'b0111_1100;
   localparam logic [7:0] S_D = 8'b0101_1110, S_DASH = 8'b0100_0000;

   logic          clk_2;
   logic          reset_n;
   logic [NS-1:0] sensor;
   logic          pump_on, alarm;
   logic [1:0]    level_code;
   logic [7:0]    seg;

   tank_level_ctrl #(.NSENS(NS), .LO_TH(LO), .HI_TH(HI), .DEB_CYCLES(DEB),
                     .FAULT_CYCLES(FC), .FILL_TIMEOUT(TO), .BLINK(BL)) dut (
      .clk_2(clk_2), .reset_n(reset_n), .sensor(sensor),
      .pump_on(pump_on), .alarm(alarm), .level_code(level_code), .seg(seg));

   initial clk_2 = 1'b0;
   always #5 clk_2 = ~clk_2;

   int n_tests = 0, n_fail = 0;

   // Reference model: modes 0 init, 1 idle, 2 fill, 3 fault.
   logic [NS-1:0] hist [0:HMAX];
   int            m_e, m_mode, m_inv, m_val, m_ev, m_kbest, m_fent;
   logic [NS-1:0] m_stable;
   bit            m_ever;
   logic          m_pump, m_alarm;
   logic [1:0]    m_lvl;
   logic [7:0]    m_seg;

   function automatic logic [NS-1:0] hv(int t);
      if (t < 1) return '0;
      return hist[t];
   endfunction

   function automatic int popc(logic [NS-1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < NS; i++) c += int'(v[i]);
      return c;
   endfunction

   function automatic logic [1:0] cls_of(logic [NS-1:0] v);
      logic [NS-1:0] vp1;
      int kk;
      vp1 = v + 1'b1;
      if ((v & vp1) != '0) return 2'b11;
      kk = popc(v);
      if (kk >= HI) return 2'b00;
      if (kk < LO)  return 2'b10;
      return 2'b01;
   endfunction

   function automatic logic [7:0] seg_of(logic [1:0] c);
      case (c)
         2'b00:   return S_A;
         2'b01:   return S_N;
         2'b10:   return S_B;
         default: return S_D;
      endcase
   endfunction

   task automatic model_reset();
      m_e = 0; m_mode = 0; m_inv = 0; m_val = 0; m_ev = 0; m_kbest = 0; m_fent = 0;
      m_stable = '0; m_ever = 0;
      m_pump = 0; m_alarm = 0; m_lvl = 2'b11; m_seg = S_DASH;
   endtask

   task automatic model_edge();
      int e, k, nxt;
      logic [1:0] c;
      bit acc, tmo, flt, rec;
      e = m_e + 1; m_e = e; hist[e] = sensor;
      c = cls_of(m_stable); k = popc(m_stable);
      flt = (m_inv >= FC); rec = (m_val >= FC);
      tmo = (m_mode == 2) && (e - 1 - m_ev >= TO);
      nxt = m_mode;
      case (m_mode)
         0: if (flt) nxt = 3; else if (m_ever && c == 2'b10) nxt = 2;
            else if (m_ever && c != 2'b11) nxt = 1;
         1: if (flt) nxt = 3; else if (c == 2'b10) nxt = 2;
         2: if (flt || tmo) nxt = 3; else if (c == 2'b00) nxt = 1;
         default: if (rec) nxt = 0;
      endcase
      if (c == 2'b11) begin m_inv++; m_val = 0; end
      else begin m_val++; m_inv = 0; end
      if (nxt == 2 && m_mode != 2) begin m_ev = e; m_kbest = k; end
      else if (nxt == 2 && k > m_kbest) begin m_ev = e; m_kbest = k; end
      m_pump = (nxt == 2); m_alarm = (nxt == 3);
      if (nxt == 3) begin
         if (m_mode != 3) m_fent = e;
         m_lvl = 2'b11;
         m_seg = (((e - m_fent) / BL) % 2 == 0) ? S_D : 8'h00;
      end else if (nxt == 0) begin
         m_lvl = 2'b11; m_seg = S_DASH;
      end else begin
         m_lvl = c; m_seg = seg_of(c);
      end
      m_mode = nxt;
      // Accepted at edge e: the last DEB synced-sample comparisons all equal,
      // and the one before them was a change (or predates reset).
      acc = (e >= DEB);
      for (int j = 0; j < DEB; j++) if (hv(e - 2 - j) != hv(e - 3 - j)) acc = 0;
      if (e - DEB >= 1 && hv(e - 2 - DEB) == hv(e - 3 - DEB)) acc = 0;
      if (acc) begin m_stable = hv(e - 2); m_ever = 1; end
   endtask

   task automatic chk(string name, int got, int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_2);
      model_edge();
      #1;
      n_tests++;
      if ({pump_on, alarm, level_code, seg} !== {m_pump, m_alarm, m_lvl, m_seg}) begin
         n_fail++;
         $display("FAIL model e=%0d: got pump=%b alarm=%b lvl=%b seg=%b expected pump=%b alarm=%b lvl=%b seg=%b",
                  m_e, pump_on, alarm, level_code, seg, m_pump, m_alarm, m_lvl, m_seg);
      end
   endtask

   task automatic run(int n);
      repeat (n) tick();
   endtask

   typedef struct {
      logic [NS-1:0] sens;
      int            hold;
      logic          pump;
      logic          alrm;
      logic [1:0]    lvl;
      logic [7:0]    sg;
   } vec_t;
   vec_t tbl [13];

   int  cyc, kk, h;
   bit  saw;

   initial begin
      reset_n = 1'b0;
      sensor  = '0;
      model_reset();
      tbl[0]  = '{4'b0000, 10, 1'b1, 1'b0, 2'b10, S_B};
      tbl[1]  = '{4'b0001, 20, 1'b1, 1'b0, 2'b01, S_N};
      tbl[2]  = '{4'b0011, 20, 1'b1, 1'b0, 2'b01, S_N};
      tbl[3]  = '{4'b0111, 20, 1'b1, 1'b0, 2'b01, S_N};
      tbl[4]  = '{4'b1111, 20, 1'b0, 1'b0, 2'b00, S_A};
      tbl[5]  = '{4'b0011, 20, 1'b0, 1'b0, 2'b01, S_N};
      tbl[6]  = '{4'b0000, 20, 1'b1, 1'b0, 2'b10, S_B};
      tbl[7]  = '{4'b0101,  5, 1'b1, 1'b0, 2'b10, S_B};
      tbl[8]  = '{4'b0011, 20, 1'b1, 1'b0, 2'b01, S_N};
      tbl[9]  = '{4'b0101, 30, 1'b0, 1'b1, 2'b11, S_D};
      tbl[10] = '{4'b0101,  5, 1'b0, 1'b1, 2'b11, 8'h00};
      tbl[11] = '{4'b0101, 16, 1'b0, 1'b1, 2'b11, S_D};
      tbl[12] = '{4'b0001, 30, 1'b0, 1'b0, 2'b01, S_N};

      #12;
      chk("reset pump", int'(pump_on), 0);
      chk("reset alarm", int'(alarm), 0);
      chk("reset level", int'(level_code), 3);
      chk("reset seg", int'(seg), int'(S_DASH));
      @(negedge clk_2);
      reset_n = 1'b1;
      model_reset();

      for (int i = 0; i < 13; i++) begin
         sensor = tbl[i].sens;
         run(tbl[i].hold);
         chk($sformatf("vec%0d pump", i),  int'(pump_on),    int'(tbl[i].pump));
         chk($sformatf("vec%0d alarm", i), int'(alarm),      int'(tbl[i].alrm));
         chk($sformatf("vec%0d level", i), int'(level_code), int'(tbl[i].lvl));
         chk($sformatf("vec%0d seg", i),   int'(seg),        int'(tbl[i].sg));
      end

      // Dry-run timeout: 64 cycles after the last level rise.
      sensor = 4'b0000; run(20);
      chk("wd pre fill", int'(pump_on), 1);
      sensor = 4'b0001; cyc = -1;
      for (int i = 1; i <= 100 && cyc < 0; i++) begin
         tick();
         if (alarm) cyc = i;
      end
      chk("wd timeout cycle", cyc, 73);
      run(5);

      // A level rise at cycle 50 re-arms the watchdog.
      sensor = 4'b0000; run(20);
      sensor = 4'b0001; saw = 0;
      for (int i = 0; i < 50; i++) begin tick(); if (alarm) saw = 1; end
      sensor = 4'b0011;
      for (int i = 0; i < 40; i++) begin tick(); if (alarm) saw = 1; end
      chk("wd rearm no alarm", int'(saw), 0);
      chk("wd rearm pump", int'(pump_on), 1);

      // Timeout and HIGH in the same cycle: the fault wins.
      sensor = 4'b1111; run(20);
      sensor = 4'b0000; run(20);
      sensor = 4'b0001; run(65);
      chk("tie pre pump", int'(pump_on), 1);
      sensor = 4'b1111; cyc = -1;
      for (int i = 1; i <= 20 && cyc < 0; i++) begin
         tick();
         if (alarm) cyc = i;
      end
      chk("tie fault cycle", cyc, 8);
      run(5);

      // Asynchronous reset mid-FILL.
      sensor = 4'b0000; run(20);
      chk("pre reset pump", int'(pump_on), 1);
      @(negedge clk_2);
      #2 reset_n = 1'b0;
      #1;
      chk("async pump", int'(pump_on), 0);
      chk("async seg", int'(seg), int'(S_DASH));
      chk("async level", int'(level_code), 3);
      repeat (2) @(posedge clk_2);
      @(negedge clk_2);
      reset_n = 1'b1;
      model_reset();
      run(10);
      chk("post reset pump", int'(pump_on), 1);
      chk("post reset seg", int'(seg), int'(S_B));

      // Inputs changing every cycle: nothing accepted, level holds.
      for (int i = 0; i < 20; i++) begin
         sensor = (i % 2 == 0) ? 4'b0111 : 4'b1111;
         tick();
      end
      chk("toggle level", int'(level_code), 2);
      chk("toggle pump", int'(pump_on), 1);

      // Randomised segments against the model.
      for (int s = 0; s < 150; s++) begin
         if ($urandom_range(0, 9) < 7) begin
            kk = $urandom_range(0, NS);
            sensor = NS'((1 << kk) - 1);
         end else begin
            sensor = NS'($urandom_range(0, 15));
         end
         h = (s % 5 == 0) ? $urandom_range(1, 3) : $urandom_range(1, 30);
         run(h);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
